// File: rtl/gb_video_pkg.sv
// Shared video-subsystem constants: STAT modes, OAM and DMA register addresses,
// and the OAM DMA sequencer state encoding.
package gb_video_pkg;

   localparam logic [1:0] HBLANK_MODE   = 2'd0;
   localparam logic [1:0] VBLANK_MODE   = 2'd1;
   localparam logic [1:0] OAM_LOCK_MODE = 2'd2;
   localparam logic [1:0] RAM_LOCK_MODE = 2'd3;

   localparam logic [15:0] OAM_BASE = 16'hFE00;
   localparam logic [15:0] OAM_END  = 16'hFE9F;
   localparam logic [15:0] DMA_REG  = 16'hFF46;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StRead,
      StWrite,
      StPad
   } dma_state_e;

endpackage

// File: rtl/oam_dma_arbiter.sv
// OAM DMA sequencer and OAM port arbiter (DMA write > PPU read > CPU access).
// Owns the FF46 page register; byte pacing is enforced by the inline cyc counter.
module oam_dma_arbiter
   import gb_video_pkg::*;
#(
   parameter int unsigned DMA_LEN     = 160,
   parameter int unsigned BYTE_CYCLES = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [15:0] A,
   input  logic [7:0]  Di,
   output logic [7:0]  Do,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        cs,
   input  logic [1:0]  ppu_mode,
   input  logic        ppu_oam_rd,
   input  logic [7:0]  ppu_oam_addr,
   output logic [7:0]  ppu_oam_data,
   output logic        ppu_oam_valid,
   output logic [15:0] dma_A,
   output logic        dma_rd_n,
   output logic        dma_req,
   input  logic        dma_gnt,
   input  logic [7:0]  dma_Di,
   output logic [7:0]  A_oam,
   output logic [7:0]  Do_oam,
   input  logic [7:0]  Di_oam,
   output logic        wr_oam_n,
   output logic        rd_oam_n,
   output logic        dma_active
);

   localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);
   localparam logic [7:0] CYC_LAST = 8'(BYTE_CYCLES - 1);

   dma_state_e state;
   logic [7:0] src_hi;
   logic [7:0] src_raw;
   logic [7:0] idx;
   logic [7:0] cyc;
   logic [7:0] dbuf;

   logic oam_hit, pad_hit, reg_hit, reg_wr;
   logic ppu_gnt, cpu_gnt, dma_wr, pad_done;
   logic [7:0] cyc_next;

   assign oam_hit  = cs && (A >= OAM_BASE) && (A <= OAM_END);
   assign pad_hit  = cs && (A > OAM_END) && (A <= {OAM_END[15:8], 8'hFF});
   assign reg_hit  = cs && (A == DMA_REG);
   assign reg_wr   = reg_hit && !wr_n;
   assign dma_wr   = (state == StWrite);
   assign ppu_gnt  = ppu_oam_rd && !dma_active;
   assign cpu_gnt  = oam_hit && !dma_active && !ppu_gnt &&
                     (ppu_mode == HBLANK_MODE || ppu_mode == VBLANK_MODE);
   // Byte slot is used up once cyc reaches the pacing limit; a long grant stall skips PAD.
   assign pad_done = (cyc >= CYC_LAST);
   assign cyc_next = (cyc == 8'hFF) ? cyc : cyc + 8'd1;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= StIdle;
         src_hi     <= 8'h00;
         src_raw    <= 8'h00;
         idx        <= 8'h00;
         cyc        <= 8'h00;
         dbuf       <= 8'h00;
         dma_active <= 1'b0;
         dma_req    <= 1'b0;
         dma_rd_n   <= 1'b1;
         dma_A      <= 16'h0000;
      end else begin
         cyc <= cyc_next;
         if (reg_wr) begin
            src_raw    <= Di;
            src_hi     <= (Di >= 8'hE0) ? Di - 8'h20 : Di;
            state      <= StStart;
            idx        <= 8'h00;
            cyc        <= 8'h00;
            dma_active <= 1'b1;
            dma_req    <= 1'b0;
            dma_rd_n   <= 1'b1;
         end else begin
            unique case (state)
               StIdle: ;
               StStart: begin
                  state    <= StRead;
                  cyc      <= 8'h00;
                  dma_req  <= 1'b1;
                  dma_rd_n <= 1'b0;
                  dma_A    <= {src_hi, 8'h00};
               end
               StRead: begin
                  if (dma_gnt) begin
                     dbuf     <= dma_Di;
                     state    <= StWrite;
                     dma_req  <= 1'b0;
                     dma_rd_n <= 1'b1;
                  end
               end
               StWrite, StPad: begin
                  if (!pad_done) begin
                     state <= StPad;
                  end else if (idx == LAST_IDX) begin
                     state      <= StIdle;
                     dma_active <= 1'b0;
                  end else begin
                     idx      <= idx + 8'd1;
                     cyc      <= 8'h00;
                     state    <= StRead;
                     dma_req  <= 1'b1;
                     dma_rd_n <= 1'b0;
                     dma_A    <= {src_hi, idx + 8'd1};
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

   always_comb begin
      A_oam    = 8'h00;
      Do_oam   = 8'h00;
      wr_oam_n = 1'b1;
      rd_oam_n = 1'b1;
      if (dma_wr) begin
         A_oam    = idx;
         Do_oam   = dbuf;
         wr_oam_n = 1'b0;
      end else if (ppu_gnt) begin
         A_oam    = ppu_oam_addr;
         rd_oam_n = 1'b0;
      end else if (cpu_gnt) begin
         A_oam = A[7:0];
         if (!wr_n) begin
            Do_oam   = Di;
            wr_oam_n = 1'b0;
         end else if (!rd_n) begin
            rd_oam_n = 1'b0;
         end
      end
   end

   always_comb begin
      Do = 8'hFF;
      if (reg_hit) begin
         Do = src_raw;
      end else if (cpu_gnt) begin
         Do = Di_oam;
      end else if (pad_hit) begin
         Do = 8'h00;
      end
   end

   assign ppu_oam_valid = ppu_gnt;
   assign ppu_oam_data  = ppu_gnt ? Di_oam : 8'hFF;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: OAM RAM and DMA source are modelled here;
// expected values are hand-derived from the transfer timing and arbitration rules.
module tb_oam_dma_arbiter;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [15:0] A;
   logic [7:0]  Di;
   logic [7:0]  Do;
   logic        rd_n, wr_n, cs;
   logic [1:0]  ppu_mode;
   logic        ppu_oam_rd;
   logic [7:0]  ppu_oam_addr;
   logic [7:0]  ppu_oam_data;
   logic        ppu_oam_valid;
   logic [15:0] dma_A;
   logic        dma_rd_n, dma_req, dma_gnt;
   logic [7:0]  dma_Di;
   logic [7:0]  A_oam, Do_oam, Di_oam;
   logic        wr_oam_n, rd_oam_n, dma_active;

   int checks   = 0;
   int failures = 0;

   logic [7:0] oam [0:255];

   always #5 clock = ~clock;

   // Source memory: page C0 holds i ^ 5A, other pages are offset so pages are distinguishable.
   function automatic logic [7:0] src_byte(input logic [15:0] a);
      return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'hC0);
   endfunction

   always @(posedge clock) if (!wr_oam_n) oam[A_oam] <= Do_oam;
   assign Di_oam = oam[A_oam];
   assign dma_Di = src_byte(dma_A);

   oam_dma_arbiter dut (
      .clock(clock), .reset_n(reset_n), .A(A), .Di(Di), .Do(Do), .rd_n(rd_n), .wr_n(wr_n),
      .cs(cs), .ppu_mode(ppu_mode), .ppu_oam_rd(ppu_oam_rd), .ppu_oam_addr(ppu_oam_addr),
      .ppu_oam_data(ppu_oam_data), .ppu_oam_valid(ppu_oam_valid), .dma_A(dma_A),
      .dma_rd_n(dma_rd_n), .dma_req(dma_req), .dma_gnt(dma_gnt), .dma_Di(dma_Di),
      .A_oam(A_oam), .Do_oam(Do_oam), .Di_oam(Di_oam), .wr_oam_n(wr_oam_n),
      .rd_oam_n(rd_oam_n), .dma_active(dma_active)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cpu_wr(input logic [15:0] addr, input logic [7:0] data);
      @(negedge clock);
      A = addr; Di = data; cs = 1'b1; wr_n = 1'b0;
      @(negedge clock);
      cs = 1'b0; wr_n = 1'b1;
   endtask

   // Called at a negedge; samples Do 1ns later, well away from the next posedge.
   task automatic cpu_rd(input string tag, input logic [15:0] addr, input logic [7:0] exp);
      A = addr; cs = 1'b1; rd_n = 1'b0;
      #1;
      chk(tag, {8'h00, Do}, {8'h00, exp});
      cs = 1'b0; rd_n = 1'b1;
   endtask

   task automatic wait_rd(input logic [15:0] addr);
      int k = 0;
      while (!(!dma_rd_n && dma_A == addr) && k < 3000) begin
         k++;
         @(negedge clock);
      end
   endtask

   // Runs to the end of the transfer; optionally withholds the grant for stall_len clocks
   // from the first READ cycle of the byte at stall_addr, and times that byte.
   task automatic run_dma(input logic [15:0] stall_addr, input int stall_len,
                          output int total, output int blen, output logic [15:0] last_rd);
      int t0 = -1;
      int t1 = -1;
      int sl = 0;
      total   = 0;
      last_rd = 16'h0000;
      while (dma_active && total < 3000) begin
         if (sl > 0) begin
            sl--;
            if (sl == 0) dma_gnt = 1'b1;
         end
         if (!dma_rd_n && dma_A == stall_addr && t0 < 0) begin
            t0 = total;
            if (stall_len > 0) begin
               dma_gnt = 1'b0;
               sl = stall_len;
            end
         end
         if (!dma_rd_n && dma_A == stall_addr + 16'd1 && t1 < 0) t1 = total;
         if (!dma_rd_n) last_rd = dma_A;
         total++;
         @(negedge clock);
      end
      blen = t1 - t0;
   endtask

   initial begin
      int total, blen;
      logic [15:0] last_rd;

      reset_n = 1'b0; A = 16'h0000; Di = 8'h00; rd_n = 1'b1; wr_n = 1'b1; cs = 1'b0;
      ppu_mode = 2'd0; ppu_oam_rd = 1'b0; ppu_oam_addr = 8'h00; dma_gnt = 1'b1;
      repeat (3) @(negedge clock);

      // Reset state
      chk("rst_active", {15'd0, dma_active}, 16'h0000);
      chk("rst_req", {15'd0, dma_req}, 16'h0000);
      chk("rst_rd_n", {15'd0, dma_rd_n}, 16'h0001);
      chk("rst_dma_A", dma_A, 16'h0000);
      chk("rst_wr_oam_n", {15'd0, wr_oam_n}, 16'h0001);
      chk("rst_rd_oam_n", {15'd0, rd_oam_n}, 16'h0001);
      chk("rst_A_oam", {8'h00, A_oam}, 16'h0000);
      chk("rst_Do_oam", {8'h00, Do_oam}, 16'h0000);
      chk("rst_ppu_valid", {15'd0, ppu_oam_valid}, 16'h0000);
      cpu_rd("rst_ff46", 16'hFF46, 8'h00);
      reset_n = 1'b1;

      // Full transfer from page C0, no stalls
      cpu_wr(16'hFF46, 8'hC0);
      run_dma(16'hC00A, 0, total, blen, last_rd);
      chk("c0_total", 16'(total), 16'd641);
      chk("c0_byte10_len", 16'(blen), 16'd4);
      chk("c0_last_A", last_rd, 16'hC09F);
      chk("c0_req_idle", {15'd0, dma_req}, 16'h0000);
      for (int i = 0; i < 160; i++) chk("c0_oam", {8'h00, oam[i]}, {8'h00, 8'(i) ^ 8'h5A});

      // Echo-page mapping: F1 -> D1, register reads back unmapped
      cpu_wr(16'hFF46, 8'hF1);
      wait_rd(16'hD100);
      chk("f1_first_A", dma_A, 16'hD100);
      chk("f1_req", {15'd0, dma_req}, 16'h0001);
      cpu_rd("f1_ff46", 16'hFF46, 8'hF1);
      run_dma(16'hD10A, 0, total, blen, last_rd);
      chk("f1_last_A", last_rd, 16'hD19F);
      chk("f1_oam0", {8'h00, oam[0]}, 16'h004B);
      chk("f1_oam159", {8'h00, oam[159]}, 16'h00D4);

      // Five-clock grant stall on byte 10
      cpu_wr(16'hFF46, 8'hC0);
      run_dma(16'hC00A, 5, total, blen, last_rd);
      chk("stall_total", 16'(total), 16'd644);
      chk("stall_byte10_len", 16'(blen), 16'd7);
      for (int i = 0; i < 160; i++) chk("stall_oam", {8'h00, oam[i]}, {8'h00, 8'(i) ^ 8'h5A});

      // CPU and PPU locked out while DMA runs
      cpu_wr(16'hFF46, 8'hC0);
      repeat (100) @(negedge clock);
      A = 16'hFE05; Di = 8'h33; cs = 1'b1; wr_n = 1'b0; ppu_oam_rd = 1'b1; ppu_oam_addr = 8'h05;
      #1;
      chk("dma_ppu_valid", {15'd0, ppu_oam_valid}, 16'h0000);
      chk("dma_ppu_data", {8'h00, ppu_oam_data}, 16'h00FF);
      @(negedge clock);
      wr_n = 1'b1; cs = 1'b0; ppu_oam_rd = 1'b0;
      cpu_rd("dma_cpu_rd", 16'hFE05, 8'hFF);
      run_dma(16'hC00A, 0, total, blen, last_rd);
      chk("dma_wr_dropped", {8'h00, oam[5]}, 16'h005F);
      cpu_wr(16'hFE05, 8'h33);
      chk("idle_wr_lands", {8'h00, oam[5]}, 16'h0033);
      cpu_rd("idle_rd", 16'hFE05, 8'h33);

      // Mode 2: PPU wins, CPU denied; other modes and address windows
      cpu_wr(16'hFE04, 8'h77);
      ppu_mode = 2'd2;
      A = 16'hFE00; cs = 1'b1; rd_n = 1'b0; ppu_oam_rd = 1'b1; ppu_oam_addr = 8'h04;
      #1;
      chk("m2_cpu_do", {8'h00, Do}, 16'h00FF);
      chk("m2_ppu_data", {8'h00, ppu_oam_data}, 16'h0077);
      chk("m2_ppu_valid", {15'd0, ppu_oam_valid}, 16'h0001);
      chk("m2_rd_oam_n", {15'd0, rd_oam_n}, 16'h0000);
      chk("m2_A_oam", {8'h00, A_oam}, 16'h0004);
      cs = 1'b0; rd_n = 1'b1; ppu_oam_rd = 1'b0;
      @(negedge clock);
      ppu_mode = 2'd1;
      cpu_rd("m1_rd", 16'hFE04, 8'h77);
      ppu_mode = 2'd3;
      cpu_rd("m3_rd", 16'hFE04, 8'hFF);
      ppu_mode = 2'd0;
      cpu_rd("unused_rd", 16'hFEA5, 8'h00);
      cpu_rd("other_rd", 16'h8000, 8'hFF);

      // Restart at byte 50 with page 80, then reset at byte 20 of the new transfer
      cpu_wr(16'hFF46, 8'hC0);
      wait_rd(16'hC032);
      A = 16'hFF46; Di = 8'h80; cs = 1'b1; wr_n = 1'b0;
      @(negedge clock);
      cs = 1'b0; wr_n = 1'b1;
      wait_rd(16'h8000);
      chk("rs_first_A", dma_A, 16'h8000);
      chk("rs_active", {15'd0, dma_active}, 16'h0001);
      wait_rd(16'h8014);
      chk("rs_byte20_A", dma_A, 16'h8014);
      reset_n = 1'b0;
      @(negedge clock);
      chk("rr_active", {15'd0, dma_active}, 16'h0000);
      chk("rr_req", {15'd0, dma_req}, 16'h0000);
      chk("rr_rd_n", {15'd0, dma_rd_n}, 16'h0001);
      chk("rr_dma_A", dma_A, 16'h0000);
      chk("rr_wr_oam_n", {15'd0, wr_oam_n}, 16'h0001);
      chk("rr_A_oam", {8'h00, A_oam}, 16'h0000);
      cpu_rd("rr_ff46", 16'hFF46, 8'h00);
      for (int i = 0; i < 20; i++)
         chk("rr_oam_p80", {8'h00, oam[i]}, {8'h00, src_byte({8'h80, 8'(i)})});
      chk("rr_oam20_kept", {8'h00, oam[20]}, 16'h004E);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/oam_dma_arbiter.md
# oam_dma_arbiter

Owns the OAM RAM port and the FF46 DMA register. Sequences 160-byte OAM DMA transfers from a 256-byte-aligned source page. Arbitrates every OAM access between the DMA engine, the PPU sprite fetcher and the CPU. Sits between the MMU, the video controller and the OAM RAM macro.

## Interface
- `DMA_LEN`, 160, bytes per transfer; also the OAM size.
- `BYTE_CYCLES`, 4, nominal clocks per transferred byte; must be ≥ 2.
- `clock` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `A` in 16: CPU address.
- `Di` in 8: CPU write data.
- `Do` out 8: CPU read data.
- `rd_n`, `wr_n` in 1: CPU strobes, active low.
- `cs` in 1: CPU chip select.
- `ppu_mode` in 2: current STAT mode; 0 = HBLANK, 1 = VBLANK, 2 = OAM lock, 3 = RAM lock.
- `ppu_oam_rd` in 1: PPU OAM read request.
- `ppu_oam_addr` in 8: PPU OAM byte index.
- `ppu_oam_data` out 8: PPU read data.
- `ppu_oam_valid` out 1: PPU read was granted this cycle.
- `dma_A` out 16: source address.
- `dma_rd_n` out 1: source read strobe.
- `dma_req` out 1: bus request to MMU.
- `dma_gnt` in 1: bus grant; `dma_Di` is valid in the same cycle.
- `dma_Di` in 8: source data.
- `A_oam` out 8: OAM byte address.
- `Do_oam` out 8: OAM write data.
- `Di_oam` in 8: OAM read data, combinational.
- `wr_oam_n`, `rd_oam_n` out 1: OAM strobes.
- `dma_active` out 1: transfer in progress.

## Operation
- DMA register (`src_hi`, 8 bits):
  - CPU write to FF46 (`cs && !wr_n`) loads `src_hi`.
  - If the value is ≥ 8'hE0, it maps to value − 8'h20 (echo RAM).
  - A read of FF46 returns the last value written, unmapped.
- Transfer states: IDLE → START → READ → WRITE → PAD → (READ | IDLE).
  - IDLE: waits for a FF46 write.
  - START: 1 clock. `idx` ← 0, `cyc` ← 0, `dma_active` ← 1.
  - READ: `dma_req` = 0→1, `dma_rd_n` = 0, `dma_A` = {`src_hi`, `idx`}. Stays until `dma_gnt`. On grant, latches `dma_Di` into `buf` and moves to WRITE.
  - WRITE: 1 clock. `A_oam` = `idx`, `Do_oam` = `buf`, `wr_oam_n` = 0.
  - PAD: holds until `cyc` == `BYTE_CYCLES` − 1; leaves immediately if `cyc` is already past that. Then:
    - if `idx` == `DMA_LEN` − 1 → IDLE, `dma_active` ← 0;
    - otherwise `idx` + 1, `cyc` ← 0, → READ.
  - `cyc` increments every clock from READ entry. It is 8 bits and saturates at 255.
- Restart: a FF46 write in any non-IDLE state returns to START with the new page. If it lands in a WRITE cycle, that byte's write still completes first.
- OAM port arbitration, fixed priority: DMA WRITE > PPU > CPU.
  - PPU is granted when `ppu_oam_rd` && !`dma_active`.
    - `ppu_oam_data` = `Di_oam` and `ppu_oam_valid` = 1 in that cycle.
    - Otherwise `ppu_oam_data` = FF and `ppu_oam_valid` = 0.
  - CPU access to FE00–FE9F is granted only when !`dma_active` && `ppu_mode` ∈ {0,1} && !PPU grant.
    - Granted read: `Do` = `Di_oam` (combinational).
    - Granted write: `wr_oam_n` = 0, `Do_oam` = `Di`, `A_oam` = A[7:0].
    - Denied: reads return FF, writes are dropped.
  - CPU access to FEA0–FEFF: reads return 00, writes are dropped.
  - `Do` = FF whenever `cs` is not hitting FE00–FE9F or FF46.
- Reset values: `src_hi` 00, state IDLE, `dma_active` 0, `dma_req` 0, `dma_rd_n` 1, `dma_A` 0000, `wr_oam_n` 1, `rd_oam_n` 1, `A_oam` 00, `Do_oam` 00, `ppu_oam_valid` 0.
- Reset mid-transfer aborts immediately. OAM keeps the bytes already written.

## Timing
- Transfer length with no grant stalls: FF46 write at edge T → `dma_active` high from T+1 for 1 + `DMA_LEN`·`BYTE_CYCLES` clocks (641 with defaults).
- Byte k (no stalls): READ at S + 4k, WRITE at S + 4k + 1, PAD at S + 4k + 2..3, where S = T + 2.
- A grant stall of n clocks lengthens byte k by max(0, n + 2 − `BYTE_CYCLES`).
- `dma_req`, `dma_A` and `dma_rd_n` are registered. The OAM strobes and the arbitration outputs are combinational from state and inputs.

## Structure
- Shared package `gb_video_pkg` holds:
  - mode constants: HBLANK_MODE, VBLANK_MODE, OAM_LOCK_MODE, RAM_LOCK_MODE;
  - OAM_BASE 16'hFE00, OAM_END 16'hFE9F, DMA_REG 16'hFF46;
  - the DMA state encoding.
- Single module with no sub-module. The byte-pacing counter is inline.

## Test plan
- Write FF46 = 8'hC0 with `dma_gnt` tied 1; source holds byte i = i ^ 8'h5A. → `dma_active` high 641 clocks; OAM[i] = i ^ 8'h5A for i = 0..159; last `dma_A` = C09F.
- Write FF46 = 8'hF1. → `dma_A` starts at D100; a FF46 read returns F1.
- Drop `dma_gnt` for 5 clocks during byte 10. → byte 10 takes 7 clocks; total = 644; data intact.
- During DMA: CPU write FE05 = 33 and read FE05; PPU `ppu_oam_rd`. → write dropped, read returns FF, `ppu_oam_valid` = 0. After DMA in mode 0, the CPU write lands.
- `ppu_mode` = 2 with CPU read FE00 and PPU read index 4 (value 77). → CPU gets FF; `ppu_oam_data` = 77, `ppu_oam_valid` = 1.
- Write FF46 = 8'h80 at byte 50, then deassert `reset_n` at byte 20 of the restarted transfer. → restart from index 0 at page 80; after reset all outputs return to their reset values; OAM[0..19] hold page-80 data.
